// File: rtl/chunked_adder_seq.sv
// Multi-cycle wide unsigned adder: one CHUNK_WIDTH slice per cycle, LSB first,
// wrapped in valid/ready handshakes on both sides.
module chunked_adder_seq #(
  parameter int unsigned ADDER_WIDTH = 140,
  parameter int unsigned CHUNK_WIDTH = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH:0]   sum,
  output logic                   busy
);

  localparam int unsigned AW     = ADDER_WIDTH;
  localparam int unsigned CW     = CHUNK_WIDTH;
  localparam int unsigned NCHUNK = AW / CW;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

  // Operand width must split into whole chunks.
  if ((AW % CW) != 0 || NCHUNK < 2) begin : g_bad_width
    $error("chunked_adder_seq: ADDER_WIDTH must be a multiple (>=2x) of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              carry_q;
  logic [AW-1:0]     a_q, b_q, result_q;
  logic [CW:0]       chunk_c;
  logic              in_ready_q, out_valid_q, busy_q;

  // Next-state decode and the single adder slice.
  always_comb begin
    state_d = state_q;
    chunk_c = {1'b0, a_q[CW-1:0]} + {1'b0, b_q[CW-1:0]} + {{CW{1'b0}}, carry_q};
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(NCHUNK - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register plus handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Operand capture, chunk shifting and carry propagation; flush keeps result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        RUN: begin
          a_q      <= a_q >> CW;
          b_q      <= b_q >> CW;
          result_q <= {chunk_c[CW-1:0], result_q[AW-1:CW]};
          carry_q  <= chunk_c[CW];
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = {carry_q, result_q};

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench for chunked_adder_seq against a full-width arithmetic model.
module tb_chunked_adder_seq;

  localparam int AW = 140;
  localparam int CW = 28;
  localparam int N  = AW / CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] a = '0;
  logic [AW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   sum;
  logic          busy;

  int total = 0;
  int bad   = 0;

  chunked_adder_seq #(.ADDER_WIDTH(AW), .CHUNK_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] model(input logic [AW-1:0] x, input logic [AW-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [AW-1:0] rand_op();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: return '1;
      1: return '0;
      default: return t[AW-1:0];
    endcase
  endfunction

  // Drives one add at negedges; reports sum, latency, DONE stability and timeout.
  task automatic do_add(input logic [AW-1:0] ta, input logic [AW-1:0] tb_v,
                        input int gap, input int hold,
                        output logic [AW:0] got, output int lat,
                        output bit stable, output bit tmo);
    int w;
    tmo = 1'b0; stable = 1'b1; lat = 0; got = '0;
    repeat (gap) @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) begin tmo = 1'b1; return; end
    a = ta; b = tb_v; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!out_valid) begin tmo = 1'b1; return; end
    got = sum;
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (sum !== got || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h, need 1 0 0 0",
               in_ready, out_valid, busy, sum);
    end
  endtask

  task automatic test_basic();
    logic [AW:0] got; int lat; bit st, tmo;
    do_add(AW'(3), AW'(5), 0, 0, got, lat, st, tmo);
    total++;
    if (tmo || got !== (AW+1)'(8)) begin
      bad++; $display("FAIL basic_sum: got %0d tmo=%b, need 8", got, tmo);
    end
    total++;
    if (lat !== N) begin
      bad++; $display("FAIL basic_latency: got %0d, need %0d", lat, N);
    end
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_ready_after: in_ready=%b busy=%b, need 1 0", in_ready, busy);
    end
  endtask

  task automatic test_carry();
    logic [AW:0] got, exp; int lat; bit st, tmo;
    logic [AW-1:0] ones;
    ones = '1;
    do_add(AW'((1 << 28) - 1), AW'(1), 0, 0, got, lat, st, tmo);
    exp = (AW+1)'(1) << 28;
    total++;
    if (tmo || got !== exp) begin
      bad++; $display("FAIL carry_chunk: got %h, need %h", got, exp);
    end
    do_add(ones, AW'(1), 1, 0, got, lat, st, tmo);
    exp = (AW+1)'(1) << AW;
    total++;
    if (tmo || got !== exp) begin
      bad++; $display("FAIL carry_full: got %h, need %h", got, exp);
    end
    do_add(ones, ones, 0, 0, got, lat, st, tmo);
    exp = {1'b1, {(AW-1){1'b1}}, 1'b0};
    total++;
    if (tmo || got !== exp) begin
      bad++; $display("FAIL max: got %h, need %h", got, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [AW:0] got, exp; int lat; bit st, tmo;
    logic [AW-1:0] x, y;
    x = rand_op(); y = rand_op(); exp = model(x, y);
    do_add(x, y, 0, 10, got, lat, st, tmo);
    total++;
    if (tmo || got !== exp) begin
      bad++; $display("FAIL bp_sum: got %h, need %h", got, exp);
    end
    total++;
    if (st !== 1'b1) begin
      bad++; $display("FAIL bp_stable: stable=%b, need 1", st);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    logic [AW:0] got; int lat; bit st, tmo, seen;
    // flush together with in_valid in IDLE must block acceptance
    flush = 1'b1; in_valid = 1'b1; a = '1; b = '1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL flush_idle: in_ready=%b busy=%b, need 1 0", in_ready, busy);
    end
    // abort at the third RUN edge
    a = '1; b = AW'(1); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL flush_abort: in_ready=%b busy=%b, need 1 0", in_ready, busy);
    end
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    total++;
    if (seen) begin
      bad++; $display("FAIL flush_no_valid: out_valid rose=%b, need 0", seen);
    end
    do_add(AW'(10), AW'(20), 0, 0, got, lat, st, tmo);
    total++;
    if (tmo || got !== (AW+1)'(30)) begin
      bad++; $display("FAIL flush_next: got %0d, need 30", got);
    end
  endtask

  task automatic test_reset_midrun();
    logic [AW:0] got, exp; int lat; bit st, tmo, seen;
    a = '1; b = '1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      bad++;
      $display("FAIL reset_midrun: in_ready=%b out_valid=%b busy=%b sum=%h, need 1 0 0 0",
               in_ready, out_valid, busy, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid || busy) seen = 1'b1; end
    total++;
    if (seen) begin
      bad++; $display("FAIL reset_no_valid: activity=%b, need 0", seen);
    end
    exp = model(AW'(12345), AW'(67890));
    do_add(AW'(12345), AW'(67890), 0, 0, got, lat, st, tmo);
    total++;
    if (tmo || got !== exp) begin
      bad++; $display("FAIL reset_next: got %0d, need %0d", got, exp);
    end
  endtask

  task automatic test_random(input int n);
    logic [AW:0] got, exp; int lat; bit st, tmo;
    logic [AW-1:0] x, y;
    for (int i = 0; i < n; i++) begin
      x = rand_op(); y = rand_op(); exp = model(x, y);
      do_add(x, y, $urandom_range(0, 2), $urandom_range(0, 3), got, lat, st, tmo);
      total++;
      if (tmo || got !== exp || st !== 1'b1) begin
        bad++;
        $display("FAIL rand_%0d: got %h stable=%b tmo=%b, need %h stable=1", i, got, st, tmo, exp);
      end
      total++;
      if (lat !== N) begin
        bad++; $display("FAIL rand_lat_%0d: got %0d, need %0d", i, lat, N);
      end
    end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_flush();
    test_reset_midrun();
    test_random(2500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
